// File: rtl/microsequencer.sv
// Next-microstate sequencer for the microprogrammed control unit: picks the next
// control-ROM address each cycle and stalls on the memory handshake with a timeout abort.
module microsequencer #(
  parameter logic [6:0] RESET_STATE = 7'd0,
  parameter logic [6:0] ABORT_STATE = 7'd91,
  parameter logic [7:0] WAIT_LIMIT  = 8'd255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] encoder_IN,
  input  logic [6:0] cr_addr_IN,
  input  logic [2:0] ns_sel_IN,
  input  logic [1:0] cond_sel_IN,
  input  logic       inv_IN,
  input  logic       moc_IN,
  input  logic       cond_IN,
  output logic [6:0] state_OUT,
  output logic       waiting_OUT,
  output logic       timeout_OUT
);

  typedef enum logic [2:0] {
    NS_DECODE  = 3'd0,
    NS_INC     = 3'd1,
    NS_JUMP    = 3'd2,
    NS_CJUMP   = 3'd3,
    NS_WAIT    = 3'd4,
    NS_CALL    = 3'd5,
    NS_RET     = 3'd6,
    NS_RESTART = 3'd7
  } nsSel_e;

  nsSel_e     nsSel;
  logic [6:0] retAddr;
  logic [7:0] waitCnt;
  logic [6:0] incState;
  logic [6:0] nextState;
  logic       testSrc;
  logic       test;
  logic       stall;
  logic       abort;

  assign nsSel    = nsSel_e'(ns_sel_IN);
  assign incState = state_OUT + 7'd1;

  always_comb begin
    testSrc = 1'b0;
    case (cond_sel_IN)
      2'b00:   testSrc = moc_IN;
      2'b01:   testSrc = cond_IN;
      2'b10:   testSrc = 1'b1;
      default: testSrc = 1'b0;
    endcase
  end

  assign test  = testSrc ^ inv_IN;
  assign stall = (nsSel == NS_WAIT) && !test;
  // A passing test on the limit cycle beats the abort, since stall is already low then.
  assign abort = stall && (waitCnt == WAIT_LIMIT);
  assign waiting_OUT = stall;

  always_comb begin
    nextState = RESET_STATE;
    case (nsSel)
      NS_DECODE:  nextState = encoder_IN;
      NS_INC:     nextState = incState;
      NS_JUMP:    nextState = cr_addr_IN;
      NS_CJUMP:   nextState = test ? cr_addr_IN : incState;
      NS_WAIT:    nextState = test ? incState : (abort ? ABORT_STATE : state_OUT);
      NS_CALL:    nextState = cr_addr_IN;
      NS_RET:     nextState = retAddr;
      NS_RESTART: nextState = RESET_STATE;
      default:    nextState = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_OUT   <= RESET_STATE;
      retAddr     <= 7'd0;
      waitCnt     <= 8'd0;
      timeout_OUT <= 1'b0;
    end else begin
      state_OUT   <= nextState;
      timeout_OUT <= abort;
      waitCnt     <= (stall && !abort) ? waitCnt + 8'd1 : 8'd0;
      if (nsSel == NS_CALL) retAddr <= incState;
    end
  end

endmodule
